// File: rtl/sc_levelsequencer_pkg.sv
// Shared game constants: sequencer state codes and default game parameters,
// used by the level sequencer and the debug display.
package sc_levelsequencer_pkg;

  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_NUM_LIVES  = 3;
  localparam int DEF_HOLD_TICKS = 60;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_IDLE      = 4'd1,
    ST_CLEAR     = 4'd2,
    ST_LOAD      = 4'd3,
    ST_PLAY      = 4'd4,
    ST_LOSE_LIFE = 4'd5,
    ST_LEVEL_UP  = 4'd6,
    ST_HOLD      = 4'd7,
    ST_GAME_OVER = 4'd8,
    ST_GAME_WON  = 4'd9
  } state_t;

endpackage

// File: rtl/sc_holdtimer.sv
// Frame-tick counter for the pause between levels/lives: zeroed by clear,
// counts ticks, done while the count equals the terminal value.
module sc_holdtimer #(
  parameter logic [7:0] TERM = 8'd60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);

  logic [7:0] cnt;

  // Saturate rather than wrap so a stale tick can never alias back to TERM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= 8'd0;
    else if (clear)               cnt <= 8'd0;
    else if (tick && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  assign done = (cnt == TERM);

endmodule

// File: rtl/sc_levelsequencer.sv
// Game level/lives sequencer: start -> clear -> load -> play, with life loss,
// level advance, timed hold between rounds and game over / game won.
module sc_levelsequencer
  import sc_levelsequencer_pkg::*;
#(
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int NUM_LIVES  = DEF_NUM_LIVES,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic       SC_LEVELSEQUENCER_CLOCK_50,
  input  logic       SC_LEVELSEQUENCER_RESET_InHigh,
  input  logic       SC_LEVELSEQUENCER_Start_InLow,
  input  logic       SC_LEVELSEQUENCER_FrameTick_InHigh,
  input  logic       SC_LEVELSEQUENCER_Goal_InHigh,
  input  logic       SC_LEVELSEQUENCER_Collision_InHigh,
  output logic       SC_LEVELSEQUENCER_clear_OutLow,
  output logic       SC_LEVELSEQUENCER_load_OutLow,
  output logic       SC_LEVELSEQUENCER_run_OutHigh,
  output logic [2:0] SC_LEVELSEQUENCER_level_Out,
  output logic [2:0] SC_LEVELSEQUENCER_lives_Out,
  output logic       SC_LEVELSEQUENCER_gameOver_OutHigh,
  output logic       SC_LEVELSEQUENCER_gameWon_OutHigh,
  output logic [3:0] SC_LEVELSEQUENCER_state_Out
);

  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [2:0] FULL_LIVES = 3'(NUM_LIVES);

  logic       clk, rst;
  logic       start_q, start_ev;
  logic       hold_done;
  state_t     state;
  logic [2:0] level, lives;

  assign clk = SC_LEVELSEQUENCER_CLOCK_50;
  assign rst = SC_LEVELSEQUENCER_RESET_InHigh;

  // Falling edge of the active-low button; a held button fires once.
  assign start_ev = !SC_LEVELSEQUENCER_Start_InLow && start_q;

  sc_holdtimer #(.TERM(8'(HOLD_TICKS))) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ST_HOLD),
    .tick  ((state == ST_HOLD) && SC_LEVELSEQUENCER_FrameTick_InHigh),
    .done  (hold_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      level   <= 3'd0;
      lives   <= FULL_LIVES;
      start_q <= 1'b1;
    end else begin
      start_q <= SC_LEVELSEQUENCER_Start_InLow;
      case (state)
        ST_RESET: state <= ST_IDLE;
        ST_IDLE, ST_GAME_OVER, ST_GAME_WON:
          if (start_ev) begin
            state <= ST_CLEAR;
            level <= 3'd0;
            lives <= FULL_LIVES;
          end
        ST_CLEAR: state <= ST_LOAD;
        ST_LOAD:  state <= ST_PLAY;
        ST_PLAY:
          // Collision has priority over a same-cycle goal.
          if (SC_LEVELSEQUENCER_Collision_InHigh) begin
            state <= ST_LOSE_LIFE;
            if (lives != 3'd0) lives <= lives - 3'd1;
          end else if (SC_LEVELSEQUENCER_Goal_InHigh) begin
            state <= ST_LEVEL_UP;
          end
        ST_LOSE_LIFE: state <= (lives == 3'd0) ? ST_GAME_OVER : ST_HOLD;
        ST_LEVEL_UP:
          if (level >= LAST_LEVEL) begin
            state <= ST_GAME_WON;
          end else begin
            state <= ST_HOLD;
            level <= level + 3'd1;
          end
        ST_HOLD: if (hold_done) state <= ST_CLEAR;
        default: state <= ST_RESET;
      endcase
    end
  end

  // Moore outputs straight from the state register, so reset reaches them
  // asynchronously together with the state.
  assign SC_LEVELSEQUENCER_clear_OutLow     = !(state == ST_RESET || state == ST_CLEAR);
  assign SC_LEVELSEQUENCER_load_OutLow      = (state != ST_LOAD);
  assign SC_LEVELSEQUENCER_run_OutHigh      = (state == ST_PLAY);
  assign SC_LEVELSEQUENCER_gameOver_OutHigh = (state == ST_GAME_OVER);
  assign SC_LEVELSEQUENCER_gameWon_OutHigh  = (state == ST_GAME_WON);
  assign SC_LEVELSEQUENCER_level_Out        = level;
  assign SC_LEVELSEQUENCER_lives_Out        = lives;
  assign SC_LEVELSEQUENCER_state_Out        = state;

endmodule

// File: tb/tb_sc_levelsequencer.sv
// Bench for sc_levelsequencer: directed vector table, hand sequences for
// game-won and async reset, then random stimulus against a reference model.
module tb_sc_levelsequencer;

  localparam int NLV = 4;
  localparam int NLI = 3;
  localparam int HT  = 2;

  logic clk = 1'b0;
  logic rst, start, tick, goal, coll;
  logic clr_n, load_n, run, gover, gwon;
  logic [2:0] level, lives;
  logic [3:0] st;

  int checks = 0;
  int failures = 0;

  sc_levelsequencer #(.NUM_LEVELS(NLV), .NUM_LIVES(NLI), .HOLD_TICKS(HT)) dut (
    .SC_LEVELSEQUENCER_CLOCK_50         (clk),
    .SC_LEVELSEQUENCER_RESET_InHigh     (rst),
    .SC_LEVELSEQUENCER_Start_InLow      (start),
    .SC_LEVELSEQUENCER_FrameTick_InHigh (tick),
    .SC_LEVELSEQUENCER_Goal_InHigh      (goal),
    .SC_LEVELSEQUENCER_Collision_InHigh (coll),
    .SC_LEVELSEQUENCER_clear_OutLow     (clr_n),
    .SC_LEVELSEQUENCER_load_OutLow      (load_n),
    .SC_LEVELSEQUENCER_run_OutHigh      (run),
    .SC_LEVELSEQUENCER_level_Out        (level),
    .SC_LEVELSEQUENCER_lives_Out        (lives),
    .SC_LEVELSEQUENCER_gameOver_OutHigh (gover),
    .SC_LEVELSEQUENCER_gameWon_OutHigh  (gwon),
    .SC_LEVELSEQUENCER_state_Out        (st)
  );

  always #5 clk = ~clk;

  // State codes
  localparam int S_RST = 0, S_IDLE = 1, S_CLR = 2, S_LOAD = 3, S_PLAY = 4,
                 S_LOSE = 5, S_LUP = 6, S_HOLD = 7, S_GO = 8, S_GW = 9;

  typedef struct {
    logic s, t, g, c;
    int   est, elvl, elives;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full output check; strobes and flags follow from the expected state.
  task automatic check_all(input string tag, input int est, input int elvl, input int elives);
    chk({tag, ".state"},  int'(st), est);
    chk({tag, ".level"},  int'(level), elvl);
    chk({tag, ".lives"},  int'(lives), elives);
    chk({tag, ".clear"},  int'(clr_n), (est == S_RST || est == S_CLR) ? 0 : 1);
    chk({tag, ".load"},   int'(load_n), (est == S_LOAD) ? 0 : 1);
    chk({tag, ".run"},    int'(run), (est == S_PLAY) ? 1 : 0);
    chk({tag, ".over"},   int'(gover), (est == S_GO) ? 1 : 0);
    chk({tag, ".won"},    int'(gwon), (est == S_GW) ? 1 : 0);
  endtask

  task automatic cyc(input logic s, input logic t, input logic g, input logic c);
    start = s; tick = t; goal = g; coll = c;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic s, t, g, c, input int est, elvl, elives);
    vec_t v;
    v.s = s; v.t = t; v.g = g; v.c = c;
    v.est = est; v.elvl = elvl; v.elives = elives;
    tbl.push_back(v);
  endtask

  // Reference model: the game rules written out directly.
  int m_st, m_lvl, m_lives, m_hold;
  logic m_prev;

  task automatic model_reset();
    m_st = S_RST; m_lvl = 0; m_lives = NLI; m_hold = 0; m_prev = 1'b1;
  endtask

  task automatic model_step(input logic s, input logic t, input logic g, input logic c);
    bit pressed;
    pressed = (s == 1'b0) && m_prev;
    m_prev = s;
    if (m_st == S_RST) m_st = S_IDLE;
    else if (m_st == S_IDLE || m_st == S_GO || m_st == S_GW) begin
      if (pressed) begin m_st = S_CLR; m_lvl = 0; m_lives = NLI; end
    end
    else if (m_st == S_CLR) m_st = S_LOAD;
    else if (m_st == S_LOAD) m_st = S_PLAY;
    else if (m_st == S_PLAY) begin
      if (c) begin m_st = S_LOSE; m_lives = (m_lives > 0) ? m_lives - 1 : 0; end
      else if (g) m_st = S_LUP;
    end
    else if (m_st == S_LOSE) begin
      m_st = (m_lives == 0) ? S_GO : S_HOLD; m_hold = 0;
    end
    else if (m_st == S_LUP) begin
      if (m_lvl == NLV - 1) m_st = S_GW;
      else begin m_lvl++; m_st = S_HOLD; m_hold = 0; end
    end
    else if (m_st == S_HOLD) begin
      if (m_hold >= HT) m_st = S_CLR;
      else if (t) m_hold++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; tick = 1'b0; goal = 1'b0; coll = 1'b0;
    #1;
    check_all("rst_async", S_RST, 0, NLI);
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_held", S_RST, 0, NLI);
    rst = 1'b0;
    #2;
    check_all("rst_release", S_RST, 0, NLI);

    // Start, level up via hold, collisions down to game over, restart.
    add(1,0,0,0, S_IDLE, 0, 3);
    add(1,0,0,0, S_IDLE, 0, 3);
    add(0,0,0,0, S_CLR,  0, 3);
    add(0,0,0,0, S_LOAD, 0, 3);
    add(0,0,0,0, S_PLAY, 0, 3);
    add(0,0,0,0, S_PLAY, 0, 3);
    add(0,0,1,0, S_LUP,  0, 3);
    add(0,0,0,0, S_HOLD, 1, 3);
    add(0,1,0,0, S_HOLD, 1, 3);
    add(0,0,0,0, S_HOLD, 1, 3);
    add(0,1,0,0, S_HOLD, 1, 3);
    add(0,0,0,0, S_CLR,  1, 3);
    add(0,0,0,0, S_LOAD, 1, 3);
    add(0,0,0,0, S_PLAY, 1, 3);
    add(1,0,1,1, S_LOSE, 1, 2);
    add(1,1,0,0, S_HOLD, 1, 2);
    add(1,1,0,0, S_HOLD, 1, 2);
    add(1,1,0,0, S_HOLD, 1, 2);
    add(1,0,0,0, S_CLR,  1, 2);
    add(1,0,0,0, S_LOAD, 1, 2);
    add(1,0,0,0, S_PLAY, 1, 2);
    add(1,0,0,1, S_LOSE, 1, 1);
    add(1,0,0,0, S_HOLD, 1, 1);
    add(1,1,0,0, S_HOLD, 1, 1);
    add(1,1,0,0, S_HOLD, 1, 1);
    add(1,0,0,0, S_CLR,  1, 1);
    add(1,0,0,0, S_LOAD, 1, 1);
    add(1,0,0,0, S_PLAY, 1, 1);
    add(1,0,0,1, S_LOSE, 1, 0);
    add(1,0,0,0, S_GO,   1, 0);
    add(1,0,1,0, S_GO,   1, 0);
    add(0,0,0,0, S_CLR,  0, 3);
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].t, tbl[i].g, tbl[i].c);
      check_all($sformatf("vec%0d", i), tbl[i].est, tbl[i].elvl, tbl[i].elives);
    end

    // Four goals from level 0 to GAME_WON; later goals ignored.
    cyc(1,0,0,0); cyc(1,0,0,0);
    check_all("won_play0", S_PLAY, 0, 3);
    for (int k = 0; k < 3; k++) begin
      cyc(1,0,1,0); cyc(1,0,0,0); cyc(1,1,0,0); cyc(1,1,0,0);
      cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
      check_all($sformatf("won_play%0d", k + 1), S_PLAY, k + 1, 3);
    end
    cyc(1,0,1,0);
    check_all("won_lup", S_LUP, 3, 3);
    cyc(1,0,0,0);
    check_all("won", S_GW, 3, 3);
    cyc(1,0,1,0);
    check_all("won_goal_ign", S_GW, 3, 3);

    // Restart, lose a life, level up, then reset with hold count at 1.
    cyc(0,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    check_all("r_play", S_PLAY, 0, 3);
    cyc(1,0,0,1); cyc(1,0,0,0); cyc(1,1,0,0); cyc(1,1,0,0);
    cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    cyc(1,0,1,0); cyc(1,0,0,0); cyc(1,1,0,0);
    check_all("r_hold1", S_HOLD, 1, 2);
    tick = 1'b0;
    #2; rst = 1'b1; #1;
    check_all("r_async", S_RST, 0, 3);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_all("r_release", S_RST, 0, 3);
    @(posedge clk); #1;
    check_all("r_idle", S_IDLE, 0, 3);

    // Random stimulus against the model, with occasional resets.
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r     = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) != 0);
      tick  = ($urandom_range(0, 2) == 0);
      goal  = ($urandom_range(0, 5) == 0);
      coll  = ($urandom_range(0, 9) == 0);
      rst   = r;
      if (r) begin
        #1;
        model_reset();
        check_all("rnd_rst", m_st, m_lvl, m_lives);
      end
      @(posedge clk); #1;
      if (r) model_reset();
      else   model_step(start, tick, goal, coll);
      check_all($sformatf("rnd%0d", i), m_st, m_lvl, m_lives);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
